fetch_unit: RTL and testbench

- Instruction-fetch front end of the rv32i pipeline.
- Generates the PC and issues single-word requests to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents one instruction per cycle to decode.
- Honours decode stalls and branch/jump redirects from execute; flushes in-flight and buffered instructions on redirect.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rv32i fetch front end: PC generation, single-outstanding imem requests, DEPTH-entry prefetch FIFO to decode.
// Head visible same cycle as count>0; requests stall when FIFO would overflow or a response is pending.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_valid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t          fifo_q [DEPTH];
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     req_pc_q, req_pc_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            outstanding_q, outstanding_d;
   logic            drop_q, drop_d;

   logic            pop;
   logic            accept;
   logic            req;
   logic [CW:0]     occ;

   always_comb begin
      pop    = (count_q != '0) && !i_stall && !i_redirect;
      accept = i_imem_valid && outstanding_q && !drop_q && !i_redirect;
      occ    = {1'b0, count_q} + (CW+1)'(accept) - (CW+1)'(pop);
      // Gated by reset so the port reads idle while reset is held.
      req    = !i_rst && !i_redirect && !drop_q && (!outstanding_q || i_imem_valid)
               && (occ < (CW+1)'(DEPTH));

      fetch_pc_d    = fetch_pc_q;
      req_pc_d      = req_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = occ[CW-1:0];
      outstanding_d = outstanding_q;
      drop_d        = drop_q;

      if (i_redirect) begin
         fetch_pc_d    = i_redirect_pc & ~32'h3;
         rd_ptr_d      = '0;
         wr_ptr_d      = '0;
         count_d       = '0;
         // A response still in flight must be swallowed when it lands.
         outstanding_d = outstanding_q && !i_imem_valid;
         drop_d        = outstanding_q && !i_imem_valid;
      end else begin
         if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
         if (drop_q && i_imem_valid) drop_d = 1'b0;
         if (req) begin
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
            outstanding_d = 1'b1;
         end else if (i_imem_valid && outstanding_q) begin
            outstanding_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc_q    <= RESET_PC;
         req_pc_q      <= RESET_PC;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= 1'b0;
         drop_q        <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         req_pc_q      <= req_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) fifo_q[wr_ptr_q] <= '{pc: req_pc_q, instr: i_imem_rdata};
   end

   assign o_imem_req  = req;
   assign o_imem_addr = fetch_pc_q;
   assign o_valid     = (count_q != '0);
   assign o_instr     = o_valid ? fifo_q[rd_ptr_q].instr : NOP_INSTR;
   assign o_pc        = o_valid ? fifo_q[rd_ptr_q].pc : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vectors with bench-driven memory responses and hand-computed outputs.
module tb_fetch_unit;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_stall = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = 32'h0;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_valid = 1'b0;
   logic [31:0] i_imem_rdata = 32'h0;
   logic        o_valid;
   logic [31:0] o_instr;
   logic [31:0] o_pc;

   localparam logic [31:0] NOP = 32'h0000_0013;

   int checks = 0;
   int errors = 0;

   fetch_unit dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_stall      (i_stall),
      .i_redirect   (i_redirect),
      .i_redirect_pc(i_redirect_pc),
      .o_imem_req   (o_imem_req),
      .o_imem_addr  (o_imem_addr),
      .i_imem_valid (i_imem_valid),
      .i_imem_rdata (i_imem_rdata),
      .o_valid      (o_valid),
      .o_instr      (o_instr),
      .o_pc         (o_pc)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        mv;
      logic [31:0] mpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   function automatic logic [31:0] tag(input logic [31:0] a);
      return 32'hC000_0000 | a;
   endfunction

   function automatic vec_t v(input logic rst, input logic stall, input logic redir,
                              input logic [31:0] rpc, input logic mv, input logic [31:0] mpc,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc);
      vec_t t;
      t.rst = rst; t.stall = stall; t.redir = redir; t.rpc = rpc;
      t.mv = mv; t.mpc = mpc; t.e_req = e_req; t.e_addr = e_addr;
      t.e_valid = e_valid; t.e_pc = e_pc;
      return t;
   endfunction

   task automatic chk(input string name, input string what, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s %s: got %08h want %08h", name, what, got, want);
      end
   endtask

   task automatic run_vec(input vec_t t, input string name);
      logic [31:0] e_instr;
      @(posedge i_clk);
      #1;
      i_rst         = t.rst;
      i_stall       = t.stall;
      i_redirect    = t.redir;
      i_redirect_pc = t.rpc;
      i_imem_valid  = t.mv;
      i_imem_rdata  = t.mv ? tag(t.mpc) : 32'hDEAD_BEEF;
      @(negedge i_clk);
      e_instr = t.e_valid ? tag(t.e_pc) : NOP;
      chk(name, "o_imem_req", {31'b0, o_imem_req}, {31'b0, t.e_req});
      chk(name, "o_imem_addr", o_imem_addr, t.e_addr);
      chk(name, "o_valid", {31'b0, o_valid}, {31'b0, t.e_valid});
      chk(name, "o_pc", o_pc, t.e_pc);
      chk(name, "o_instr", o_instr, e_instr);
   endtask

   vec_t tbl[$];

   initial begin
      // Fields: rst stall redir rpc | mem_valid mem_pc | exp req addr valid pc
      // Stream with 1-cycle memory, then a mid-operation reset.
      tbl.push_back(v(1,0,0,0, 0,0,        0,32'h0,  0,32'h0));
      tbl.push_back(v(0,0,0,0, 0,0,        1,32'h0,  0,32'h0));
      tbl.push_back(v(0,0,0,0, 1,32'h0,    1,32'h4,  0,32'h0));
      tbl.push_back(v(0,0,0,0, 1,32'h4,    1,32'h8,  1,32'h0));
      tbl.push_back(v(0,0,0,0, 1,32'h8,    1,32'hC,  1,32'h4));
      tbl.push_back(v(0,0,0,0, 1,32'hC,    1,32'h10, 1,32'h8));
      tbl.push_back(v(1,0,0,0, 0,0,        0,32'h0,  0,32'h0));
      // Late response after reset is ignored; then stall 5 cycles from first valid.
      tbl.push_back(v(0,0,0,0, 1,32'h10,   1,32'h0,  0,32'h0));
      tbl.push_back(v(0,0,0,0, 1,32'h0,    1,32'h4,  0,32'h0));
      tbl.push_back(v(0,1,0,0, 1,32'h4,    0,32'h8,  1,32'h0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(v(0,1,0,0, 0,0,     0,32'h8,  1,32'h0));
      tbl.push_back(v(0,0,0,0, 0,0,        1,32'h8,  1,32'h0));
      tbl.push_back(v(0,0,0,0, 1,32'h8,    1,32'hC,  1,32'h4));
      // Reset with one buffered entry and a request outstanding.
      tbl.push_back(v(1,0,0,0, 0,0,        0,32'h0,  0,32'h0));
      tbl.push_back(v(0,0,0,0, 1,32'hC,    1,32'h0,  0,32'h0));
      tbl.push_back(v(0,0,0,0, 1,32'h0,    1,32'h4,  0,32'h0));
      tbl.push_back(v(0,0,0,0, 1,32'h4,    1,32'h8,  1,32'h0));
      tbl.push_back(v(0,0,0,0, 0,0,        0,32'hC,  1,32'h4));
      tbl.push_back(v(0,0,0,0, 1,32'h8,    1,32'hC,  0,32'h0));

      @(negedge i_clk);
      for (int i = 0; i < tbl.size(); i++)
         run_vec(tbl[i], $sformatf("vec%0d", i));

      // 3-cycle memory; redirect to 0x100 one cycle after the request for 0x8.
      run_vec(v(1,0,0,0,          0,0,         0,32'h0,   0,32'h0),   "rd1_rst");
      run_vec(v(0,0,0,0,          0,0,         1,32'h0,   0,32'h0),   "rd1_c0");
      run_vec(v(0,0,0,0,          0,0,         0,32'h4,   0,32'h0),   "rd1_c1");
      run_vec(v(0,0,0,0,          0,0,         0,32'h4,   0,32'h0),   "rd1_c2");
      run_vec(v(0,0,0,0,          1,32'h0,     1,32'h4,   0,32'h0),   "rd1_c3");
      run_vec(v(0,0,0,0,          0,0,         0,32'h8,   1,32'h0),   "rd1_c4");
      run_vec(v(0,0,0,0,          0,0,         0,32'h8,   0,32'h0),   "rd1_c5");
      run_vec(v(0,0,0,0,          1,32'h4,     1,32'h8,   0,32'h0),   "rd1_c6");
      run_vec(v(0,0,1,32'h100,    0,0,         0,32'hC,   1,32'h4),   "rd1_redir");
      run_vec(v(0,0,0,0,          0,0,         0,32'h100, 0,32'h0),   "rd1_flushed");
      run_vec(v(0,0,0,0,          1,32'h8,     0,32'h100, 0,32'h0),   "rd1_dropped");
      run_vec(v(0,0,0,0,          0,0,         1,32'h100, 0,32'h0),   "rd1_newreq");
      run_vec(v(0,0,0,0,          0,0,         0,32'h104, 0,32'h0),   "rd1_w1");
      run_vec(v(0,0,0,0,          0,0,         0,32'h104, 0,32'h0),   "rd1_w2");
      run_vec(v(0,0,0,0,          1,32'h100,   1,32'h104, 0,32'h0),   "rd1_resp");
      run_vec(v(0,0,0,0,          0,0,         0,32'h108, 1,32'h100), "rd1_first");
      // Redirect to 0x200 in the same cycle as a response.
      run_vec(v(0,0,0,0,          0,0,         0,32'h108, 0,32'h0),   "rd2_w");
      run_vec(v(0,0,1,32'h200,    1,32'h104,   0,32'h108, 0,32'h0),   "rd2_redir");
      run_vec(v(0,0,0,0,          0,0,         1,32'h200, 0,32'h0),   "rd2_newreq");
      run_vec(v(0,0,0,0,          0,0,         0,32'h204, 0,32'h0),   "rd2_w1");
      run_vec(v(0,0,0,0,          0,0,         0,32'h204, 0,32'h0),   "rd2_w2");
      run_vec(v(0,0,0,0,          1,32'h200,   1,32'h204, 0,32'h0),   "rd2_resp");
      run_vec(v(0,0,0,0,          0,0,         0,32'h208, 1,32'h200), "rd2_first");
      // Redirect to unaligned 0x102 while decode stalls.
      run_vec(v(0,1,0,0,          0,0,         0,32'h208, 0,32'h0),   "rd3_w");
      run_vec(v(0,1,0,0,          1,32'h204,   1,32'h208, 0,32'h0),   "rd3_fill");
      run_vec(v(0,1,0,0,          0,0,         0,32'h20C, 1,32'h204), "rd3_held");
      run_vec(v(0,1,1,32'h102,    0,0,         0,32'h20C, 1,32'h204), "rd3_redir");
      run_vec(v(0,1,0,0,          1,32'h208,   0,32'h100, 0,32'h0),   "rd3_dropped");
      run_vec(v(0,0,0,0,          0,0,         1,32'h100, 0,32'h0),   "rd3_newreq");
      run_vec(v(0,0,0,0,          1,32'h100,   1,32'h104, 0,32'h0),   "rd3_resp");
      run_vec(v(0,0,0,0,          1,32'h104,   1,32'h108, 1,32'h100), "rd3_first");
      // Redirect to the top word; fetch PC wraps to zero.
      run_vec(v(0,0,1,32'hFFFF_FFFF, 1,32'h108, 0,32'h10C, 1,32'h104), "wrap_redir");
      run_vec(v(0,0,0,0,          0,0,         1,32'hFFFF_FFFC, 0,32'h0), "wrap_req");
      run_vec(v(0,0,0,0,          1,32'hFFFF_FFFC, 1,32'h0, 0,32'h0),  "wrap_next");
      run_vec(v(0,0,0,0,          1,32'h0,     1,32'h4,   1,32'hFFFF_FFFC), "wrap_top");
      run_vec(v(0,0,0,0,          0,0,         0,32'h8,   1,32'h0),   "wrap_zero");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
